sync_shape_pp: RTL



---
 rtl/sync_shape_pp_pkg.sv | 30 +++
 rtl/sync_shape_bank.sv | 160 ++++++++++++++++
 rtl/sync_shape_pp.sv | 56 +++++
 3 files changed

// File: rtl/sync_shape_pp_pkg.sv
// sync_shape_pp_pkg
// Shared types and helpers for the systolic-array deskew stage.
//   buf_state_e : lifecycle of one tile buffer inside a bank
//   cnt_width   : width of the input beat counter (covers L+NUM_ROW-1 beats)
//   clamp_len   : maps a requested tile length onto 1..DEPTH
package sync_shape_pp_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL  = 2'd1,
    FULL  = 2'd2,
    DRAIN = 2'd3
  } buf_state_e;

  localparam int DEF_ACT_WIDTH = 8;
  localparam int DEF_NUM_ROW   = 16;
  localparam int DEF_NUM_BANK  = 4;
  localparam int DEF_DEPTH     = 16;

  // The beat index of a tile runs up to DEPTH+NUM_ROW-2.
  function automatic int cnt_width(input int depth, input int num_row);
    return $clog2(depth + num_row);
  endfunction

  // Zero and out-of-range lengths both mean "a full-depth tile".
  function automatic int clamp_len(input int len, input int depth);
    return ((len == 0) || (len > depth)) ? depth : len;
  endfunction

endpackage

// File: rtl/sync_shape_bank.sv
// sync_shape_bank
// One bank of the deskew stage: collects a diagonal wavefront into one of
// two tile buffers and replays the tile as aligned column words.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   cfg_len    : requested tile length, captured on beat 0 of a tile
//   in_data    : NUM_ROW activations, row r at [r*ACT_WIDTH +: ACT_WIDTH]
//   in_vld/rdy : input beat handshake
//   out_data   : aligned word, same row packing as in_data (0 when idle)
//   out_vld/rdy: output word handshake
//   out_last   : final word of a tile
module sync_shape_bank
  import sync_shape_pp_pkg::*;
#(
  parameter int ACT_WIDTH = DEF_ACT_WIDTH,
  parameter int NUM_ROW   = DEF_NUM_ROW,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int LEN_W     = $clog2(DEPTH + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [LEN_W-1:0]             cfg_len,
  input  logic [NUM_ROW*ACT_WIDTH-1:0] in_data,
  input  logic                         in_vld,
  output logic                         in_rdy,
  output logic [NUM_ROW*ACT_WIDTH-1:0] out_data,
  output logic                         out_vld,
  input  logic                         out_rdy,
  output logic                         out_last
);

  localparam int CNT_W = cnt_width(DEPTH, NUM_ROW);

  buf_state_e                                     state_q [2];
  buf_state_e                                     state_d [2];
  logic [1:0][LEN_W-1:0]                          len_q;
  logic                                           wb_q;
  logic                                           rb_q;
  logic [CNT_W-1:0]                               in_cnt_q;
  logic [LEN_W-1:0]                               rd_cnt_q;
  logic [1:0][DEPTH-1:0][NUM_ROW-1:0][ACT_WIDTH-1:0] mem_q;

  logic [LEN_W-1:0]                cfg_len_eff;
  logic [LEN_W-1:0]                wr_len;
  logic                            in_fire;
  logic                            in_last;
  logic                            out_fire;
  logic                            rd_last;
  logic [DEPTH-1:0][NUM_ROW-1:0]   wr_en;

  // Handshake and tile-boundary decode. Beat 0 uses the live clamped length
  // because the filling buffer has not latched it yet; later beats use the
  // latched copy so mid-tile cfg_len changes are ignored. Both valid/ready
  // are held low during reset so nothing is exchanged while state is cleared.
  always_comb begin
    cfg_len_eff = LEN_W'(clamp_len(int'(cfg_len), DEPTH));
    wr_len      = (in_cnt_q == '0) ? cfg_len_eff : len_q[wb_q];
    in_rdy      = !rst && ((state_q[wb_q] == EMPTY) || (state_q[wb_q] == FILL));
    out_vld     = !rst && ((state_q[rb_q] == FULL) || (state_q[rb_q] == DRAIN));
    in_fire     = in_vld && in_rdy;
    out_fire    = out_vld && out_rdy;
    in_last     = (int'(in_cnt_q) == int'(wr_len) + NUM_ROW - 2);
    rd_last     = (rd_cnt_q == len_q[rb_q] - LEN_W'(1));
    out_last    = out_vld && rd_last;
  end

  // On beat k, row r holds element k-r; only slots inside the tile are
  // written so the skew padding never reaches storage.
  always_comb begin
    for (int j = 0; j < DEPTH; j++) begin
      for (int r = 0; r < NUM_ROW; r++) begin
        wr_en[j][r] = in_fire && (int'(in_cnt_q) == j + r) && (j < int'(wr_len));
      end
    end
  end

  // Per-buffer lifecycle. The write side only ever touches the buffer under
  // wb and the read side the buffer under rb; they cannot be the same buffer
  // in one cycle because a buffer is either fillable or drainable.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      state_d[b] = state_q[b];
      if (in_fire && (wb_q == 1'(b))) begin
        state_d[b] = in_last ? FULL : FILL;
      end
      if (out_fire && (rb_q == 1'(b))) begin
        state_d[b] = rd_last ? EMPTY : DRAIN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q[0] <= EMPTY;
      state_q[1] <= EMPTY;
    end else begin
      state_q[0] <= state_d[0];
      state_q[1] <= state_d[1];
    end
  end

  // Beat and word counters return to zero at each tile boundary, which is
  // also where the write/read buffer pointers swap.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_q     <= 1'b0;
      rb_q     <= 1'b0;
      in_cnt_q <= '0;
      rd_cnt_q <= '0;
      len_q    <= '0;
    end else begin
      if (in_fire) begin
        if (in_cnt_q == '0) begin
          len_q[wb_q] <= cfg_len_eff;
        end
        if (in_last) begin
          in_cnt_q <= '0;
          wb_q     <= ~wb_q;
        end else begin
          in_cnt_q <= in_cnt_q + CNT_W'(1);
        end
      end
      if (out_fire) begin
        if (rd_last) begin
          rd_cnt_q <= '0;
          rb_q     <= ~rb_q;
        end else begin
          rd_cnt_q <= rd_cnt_q + LEN_W'(1);
        end
      end
    end
  end

  // Tile storage needs no reset: buffer state alone decides what is visible.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 2; b++) begin
      for (int j = 0; j < DEPTH; j++) begin
        for (int r = 0; r < NUM_ROW; r++) begin
          if (wr_en[j][r] && (wb_q == 1'(b))) begin
            mem_q[b][j][r] <= in_data[r*ACT_WIDTH +: ACT_WIDTH];
          end
        end
      end
    end
  end

  // Word j of the draining buffer is already row-packed; forced to zero
  // whenever no word is being offered.
  always_comb begin
    out_data = '0;
    if (out_vld) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (rd_cnt_q == LEN_W'(j)) begin
          out_data = mem_q[rb_q][j];
        end
      end
    end
  end

endmodule

// File: rtl/sync_shape_pp.sv
// sync_shape_pp
// Double-buffered deskew stage between the PE array and the SRAM write-back
// packer. NUM_BANK independent sync_shape_bank instances; this level only
// slices the flat buses.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   cfg_len    : tile length shared by all banks (each bank samples its own)
//   in_data    : bank b row r at [(b*NUM_ROW+r)*ACT_WIDTH +: ACT_WIDTH]
//   in_vld/rdy : per-bank input handshake
//   out_data   : aligned words, same packing as in_data
//   out_vld/rdy: per-bank output handshake
//   out_last   : per-bank final word of a tile
module sync_shape_pp
  import sync_shape_pp_pkg::*;
#(
  parameter int ACT_WIDTH = DEF_ACT_WIDTH,
  parameter int NUM_ROW   = DEF_NUM_ROW,
  parameter int NUM_BANK  = DEF_NUM_BANK,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int LEN_W     = $clog2(DEPTH + 1)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [LEN_W-1:0]                      cfg_len,
  input  logic [NUM_BANK*NUM_ROW*ACT_WIDTH-1:0] in_data,
  input  logic [NUM_BANK-1:0]                   in_vld,
  output logic [NUM_BANK-1:0]                   in_rdy,
  output logic [NUM_BANK*NUM_ROW*ACT_WIDTH-1:0] out_data,
  output logic [NUM_BANK-1:0]                   out_vld,
  input  logic [NUM_BANK-1:0]                   out_rdy,
  output logic [NUM_BANK-1:0]                   out_last
);

  localparam int BANK_W = NUM_ROW * ACT_WIDTH;

  for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
    sync_shape_bank #(
      .ACT_WIDTH (ACT_WIDTH),
      .NUM_ROW   (NUM_ROW),
      .DEPTH     (DEPTH),
      .LEN_W     (LEN_W)
    ) u_bank (
      .clk      (clk),
      .rst      (rst),
      .cfg_len  (cfg_len),
      .in_data  (in_data[b*BANK_W +: BANK_W]),
      .in_vld   (in_vld[b]),
      .in_rdy   (in_rdy[b]),
      .out_data (out_data[b*BANK_W +: BANK_W]),
      .out_vld  (out_vld[b]),
      .out_rdy  (out_rdy[b]),
      .out_last (out_last[b])
    );
  end

endmodule
